ads5404_capture_align: RTL and testbench
========================================

ADS5404_CAPTURE_ALIGN -- requirements
Module: ads5404_capture_align

Interface
REQ-001 SHALL have parameter NBITS, default 12, meaning sample width per lane.
REQ-002 SHALL have parameter LEN_W, default 16, meaning width of the capture-length field.
REQ-003 SHALL have port clk  in  1  the ADC user clock; the only clock.
REQ-004 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-005 SHALL have ports da_0, da_1, db_0, db_1  in  NBITS each  ADC samples, lane 0 earlier in time than lane 1.
REQ-006 SHALL have ports sync_0, sync_1  in  1 each  ADC sync marker per lane.
REQ-007 SHALL have ports ovra_0, ovra_1, ovrb_0, ovrb_1  in  1 each  overrange flag per lane.
REQ-008 SHALL have port arm  in  1  capture request, level-sampled.
REQ-009 SHALL have port use_sync  in  1  1 = start on sync edge; 0 = start immediately.
REQ-010 SHALL have port cap_len  in  LEN_W  number of output words per capture.
REQ-011 SHALL have port ovr_clr  in  1  clears the counters.
REQ-012 SHALL have port dout  out  4*NBITS  {db_l1, db_l0, da_l1, da_l0}, aligned.
REQ-013 SHALL have port dout_ovr  out  4  {ovrb_l1, ovrb_l0, ovra_l1, ovra_l0}, aligned like dout.
REQ-014 SHALL have ports dout_valid, dout_first, dout_last  out  1 each  word strobes.
REQ-015 SHALL have ports busy, done  out  1 each  status.
REQ-016 SHALL have port sync_phase  out  1  lane of the sync edge that started the capture.
REQ-017 SHALL have ports sync_cnt, ovra_cnt, ovrb_cnt  out  16 each  saturating event counters.

Function
REQ-018 SHALL register all data, sync and ovr inputs into stage R1, then R1 into stage R2; dout and the strobes SHALL be registered from R2/R1.
REQ-019 SHALL detect a sync edge on R1 as follows: lane 0 edge = sync_0 & ~(previous-cycle sync_1); lane 1 edge = sync_1 & ~sync_0; the two are mutually exclusive.
REQ-020 SHALL have FSM states IDLE, ARMED, CAPTURE, DONE.
REQ-021 FSM transitions: IDLE -> ARMED when arm=1; ARMED -> CAPTURE on the next cycle if use_sync=0, else on an R1 sync edge; CAPTURE -> DONE after cap_len words are output; DONE -> ARMED when arm=1.
REQ-022 On entering CAPTURE, sync_phase SHALL latch the edge lane (0 when use_sync=0) and hold until the next capture start.
REQ-023 With phase 0, the word lanes SHALL be R2 lane0, R2 lane1; with phase 1, word lane0 = R2 lane1 and word lane1 = R1 lane0. The same mapping SHALL apply to dout_ovr.
REQ-024 Latency: the first output word SHALL contain the sync sample in lane 0 and SHALL appear 3 cycles after that input was presented. With use_sync=0, the first word SHALL be the input presented on the cycle arm is first seen in IDLE or DONE, also at +3 cycles.
REQ-025 During CAPTURE, dout_valid SHALL be 1 on every cycle, for exactly cap_len consecutive cycles.
REQ-026 dout_first SHALL mark the first valid word, and dout_last SHALL mark the cap_len-th word; for cap_len=1 both SHALL be asserted on the same word.
REQ-027 cap_len SHALL be sampled on entry to CAPTURE.
REQ-028 cap_len=0 SHALL go CAPTURE -> DONE with no valid word.
REQ-029 When dout_valid=0, dout SHALL hold its last value.
REQ-030 busy SHALL be 1 in ARMED and CAPTURE; done SHALL be 1 in DONE only.
REQ-031 arm SHALL be ignored in ARMED and CAPTURE.
REQ-032 sync_cnt SHALL increment by 1 for each detected edge in any state.
REQ-033 ovra_cnt and ovrb_cnt SHALL increment by popcount of the R1 lane flags (0..2) each cycle.
REQ-034 All counters SHALL saturate at 0xFFFF.
REQ-035 When ovr_clr and an increment occur in the same cycle, the counter SHALL be 0.

Reset
REQ-036 While rst=1, the FSM SHALL be IDLE, R1/R2 SHALL be 0, dout SHALL be 0, dout_ovr SHALL be 0, all strobes SHALL be 0, busy=0, done=0, sync_phase=0, and all counters SHALL be 0.
REQ-037 rst during CAPTURE SHALL abort the capture on the next cycle with no dout_last, and no further valid words SHALL be output.

Verification
REQ-038 Scenario: use_sync=1, cap_len=4, arm; sync_0=1 on cycle t (sync_1 low on t-1) -> dout_valid on t+3..t+6, first word = inputs of t, phase 0, dout_last on t+6, done on t+7.
REQ-039 Scenario: same setup, but sync_0=0, sync_1=1 on t -> sync_phase=1; first word lane0 = da_1(t), lane1 = da_0(t+1).
REQ-040 Scenario: use_sync=0, cap_len=1, arm on cycle a -> single word containing inputs of a on a+3 with first=last=1; cap_len=0 -> done with no valid.
REQ-041 Scenario: ovra_0=ovra_1=1 for 40000 cycles -> ovra_cnt=0xFFFF; then ovr_clr together with ovra high -> ovra_cnt=0.
REQ-042 Scenario: rst mid-capture of cap_len=100 at word 50 -> no further dout_valid, no dout_last, state IDLE, all counters 0; arm in CAPTURE is ignored.

Source files
------------

// File: rtl/ads5404_capture_align.sv
// ADS5404 capture aligner: two-stage input pipeline, sync-edge lane detection,
// armed capture of cap_len aligned words, and saturating sync/overrange counters.
module ads5404_capture_align #(
    parameter int unsigned NBITS = 12,
    parameter int unsigned LEN_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NBITS-1:0]     da_0,
    input  logic [NBITS-1:0]     da_1,
    input  logic [NBITS-1:0]     db_0,
    input  logic [NBITS-1:0]     db_1,
    input  logic                 sync_0,
    input  logic                 sync_1,
    input  logic                 ovra_0,
    input  logic                 ovra_1,
    input  logic                 ovrb_0,
    input  logic                 ovrb_1,
    input  logic                 arm,
    input  logic                 use_sync,
    input  logic [LEN_W-1:0]     cap_len,
    input  logic                 ovr_clr,
    output logic [4*NBITS-1:0]   dout,
    output logic [3:0]           dout_ovr,
    output logic                 dout_valid,
    output logic                 dout_first,
    output logic                 dout_last,
    output logic                 busy,
    output logic                 done,
    output logic                 sync_phase,
    output logic [15:0]          sync_cnt,
    output logic [15:0]          ovra_cnt,
    output logic [15:0]          ovrb_cnt
);

    localparam int unsigned N = NBITS;

    typedef enum logic [1:0] {StIdle, StArmed, StCapture, StDone} state_t;

    // Lane packing everywhere: {b lane1, b lane0, a lane1, a lane0}
    logic [4*N-1:0]   r_r1_data;
    logic [4*N-1:0]   r_r2_data;
    logic [1:0]       r_r1_sync;
    logic             r_r2_sync_1;
    logic [3:0]       r_r1_ovr;
    logic [3:0]       r_r2_ovr;

    state_t           r_state;
    state_t           w_state_d;
    logic             w_start;
    logic             w_start_phase;
    logic             w_issue;
    logic             w_edge0;
    logic             w_edge1;
    logic [LEN_W-1:0] r_word_cnt;
    logic [LEN_W-1:0] r_len;
    logic             r_phase;

    logic [4*N-1:0]   w_word;
    logic [3:0]       w_word_ovr;
    logic [4*N-1:0]   r_dout;
    logic [3:0]       r_dout_ovr;
    logic             r_dout_valid;
    logic             r_dout_first;
    logic             r_dout_last;

    logic [15:0]      r_sync_cnt;
    logic [15:0]      r_ovra_cnt;
    logic [15:0]      r_ovrb_cnt;

    function automatic logic [15:0] f_sat_add(input logic [15:0] a, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, a} + {15'd0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    // Input pipeline R1 -> R2.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_r1_data   <= '0;
            r_r2_data   <= '0;
            r_r1_sync   <= '0;
            r_r2_sync_1 <= 1'b0;
            r_r1_ovr    <= '0;
            r_r2_ovr    <= '0;
        end else begin
            r_r1_data   <= {db_1, db_0, da_1, da_0};
            r_r2_data   <= r_r1_data;
            r_r1_sync   <= {sync_1, sync_0};
            r_r2_sync_1 <= r_r1_sync[1];
            r_r1_ovr    <= {ovrb_1, ovrb_0, ovra_1, ovra_0};
            r_r2_ovr    <= r_r1_ovr;
        end
    end

    // Lane-0 edge looks back at last cycle's lane 1 so a sync spanning the
    // lane boundary is reported once, on lane 1.
    assign w_edge0 = r_r1_sync[0] & ~r_r2_sync_1;
    assign w_edge1 = r_r1_sync[1] & ~r_r1_sync[0];

    assign w_issue = (r_state == StCapture) && (r_word_cnt != r_len);

    // Next-state logic and capture start decision.
    always_comb begin
        w_state_d     = r_state;
        w_start       = 1'b0;
        w_start_phase = 1'b0;
        case (r_state)
            StIdle, StDone: begin
                if (arm) w_state_d = StArmed;
            end
            StArmed: begin
                if (!use_sync) begin
                    w_start   = 1'b1;
                    w_state_d = StCapture;
                end else if (w_edge0 || w_edge1) begin
                    w_start       = 1'b1;
                    w_start_phase = w_edge1;
                    w_state_d     = StCapture;
                end
            end
            StCapture: begin
                if (r_word_cnt == r_len) w_state_d = StDone;
            end
            default: w_state_d = StIdle;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= StIdle;
        else     r_state <= w_state_d;
    end

    // Per-capture context: word counter, sampled length, alignment phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word_cnt <= '0;
            r_len      <= '0;
            r_phase    <= 1'b0;
        end else if (w_start) begin
            r_word_cnt <= '0;
            r_len      <= cap_len;
            r_phase    <= w_start_phase;
        end else if (w_issue) begin
            r_word_cnt <= r_word_cnt + LEN_W'(1);
        end
    end

    // Phase 1 shifts the word by one lane: R2 lane1 then the newer R1 lane0.
    assign w_word = r_phase ? {r_r1_data[2*N +: N], r_r2_data[3*N +: N],
                               r_r1_data[0 +: N],   r_r2_data[N +: N]}
                            : r_r2_data;
    assign w_word_ovr = r_phase ? {r_r1_ovr[2], r_r2_ovr[3], r_r1_ovr[0], r_r2_ovr[1]}
                                : r_r2_ovr;

    // Output word register and strobes; dout holds between valid words.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout       <= '0;
            r_dout_ovr   <= '0;
            r_dout_valid <= 1'b0;
            r_dout_first <= 1'b0;
            r_dout_last  <= 1'b0;
        end else begin
            r_dout_valid <= w_issue;
            r_dout_first <= w_issue && (r_word_cnt == '0);
            r_dout_last  <= w_issue && (r_word_cnt == r_len - LEN_W'(1));
            if (w_issue) begin
                r_dout     <= w_word;
                r_dout_ovr <= w_word_ovr;
            end
        end
    end

    // Saturating event counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || ovr_clr) begin
            r_sync_cnt <= '0;
            r_ovra_cnt <= '0;
            r_ovrb_cnt <= '0;
        end else begin
            r_sync_cnt <= f_sat_add(r_sync_cnt, {1'b0, w_edge0 | w_edge1});
            r_ovra_cnt <= f_sat_add(r_ovra_cnt, {1'b0, r_r1_ovr[0]} + {1'b0, r_r1_ovr[1]});
            r_ovrb_cnt <= f_sat_add(r_ovrb_cnt, {1'b0, r_r1_ovr[2]} + {1'b0, r_r1_ovr[3]});
        end
    end

    assign dout       = r_dout;
    assign dout_ovr   = r_dout_ovr;
    assign dout_valid = r_dout_valid;
    assign dout_first = r_dout_first;
    assign dout_last  = r_dout_last;
    assign busy       = (r_state == StArmed) || (r_state == StCapture);
    assign done       = (r_state == StDone);
    assign sync_phase = r_phase;
    assign sync_cnt   = r_sync_cnt;
    assign ovra_cnt   = r_ovra_cnt;
    assign ovrb_cnt   = r_ovrb_cnt;

endmodule

// File: tb/tb_ads5404_capture_align.sv
// Self-checking bench: random and directed stimulus against a schedule-based
// reference model that works from the recorded per-cycle input history.
module tb_ads5404_capture_align;

    localparam int NBITS = 12;
    localparam int LEN_W = 16;
    localparam int MAXC  = 60000;

    typedef struct packed {
        logic [NBITS-1:0] da0, da1, db0, db1;
        logic             s0, s1, oa0, oa1, ob0, ob1;
        logic             arm, us, clr, rst;
        logic [LEN_W-1:0] len;
    } stim_t;

    logic                 clk;
    logic                 rst;
    logic [NBITS-1:0]     da_0, da_1, db_0, db_1;
    logic                 sync_0, sync_1, ovra_0, ovra_1, ovrb_0, ovrb_1;
    logic                 arm, use_sync, ovr_clr;
    logic [LEN_W-1:0]     cap_len;
    logic [4*NBITS-1:0]   dout;
    logic [3:0]           dout_ovr;
    logic                 dout_valid, dout_first, dout_last, busy, done, sync_phase;
    logic [15:0]          sync_cnt, ovra_cnt, ovrb_cnt;

    ads5404_capture_align #(.NBITS(NBITS), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .da_0       (da_0),
        .da_1       (da_1),
        .db_0       (db_0),
        .db_1       (db_1),
        .sync_0     (sync_0),
        .sync_1     (sync_1),
        .ovra_0     (ovra_0),
        .ovra_1     (ovra_1),
        .ovrb_0     (ovrb_0),
        .ovrb_1     (ovrb_1),
        .arm        (arm),
        .use_sync   (use_sync),
        .cap_len    (cap_len),
        .ovr_clr    (ovr_clr),
        .dout       (dout),
        .dout_ovr   (dout_ovr),
        .dout_valid (dout_valid),
        .dout_first (dout_first),
        .dout_last  (dout_last),
        .busy       (busy),
        .done       (done),
        .sync_phase (sync_phase),
        .sync_cnt   (sync_cnt),
        .ovra_cnt   (ovra_cnt),
        .ovrb_cnt   (ovrb_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    stim_t hist [MAXC];
    int    n;
    int    n_cmp;
    int    n_err;

    // Reference model: mode 0 idle, 1 armed, 2 capture scheduled (then done).
    int                 m_mode;
    int                 m_s;     // input cycle of the first captured sample
    int                 m_l;     // captured length
    bit                 m_p;
    bit                 m_ready;
    logic [4*NBITS-1:0] m_dout;
    logic [3:0]         m_ovr;
    int                 m_sc, m_ac, m_bc;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s at cycle %0d: got %0h, want %0h", tag, n, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    // Advance the model over the clock edge that ends input cycle c.
    task automatic model_step(input int c);
        stim_t x, p1, p2;
        bit e0, e1;
        x  = hist[c];
        p1 = hist[c-1];
        p2 = hist[c-2];
        if (x.rst) begin
            m_mode = 0; m_s = 0; m_l = 0; m_p = 1'b0;
            m_dout = '0; m_ovr = '0;
            m_sc = 0; m_ac = 0; m_bc = 0;
            m_ready = 1'b1;
            return;
        end
        e0 = p1.s0 && !p2.s1;
        e1 = p1.s1 && !p1.s0;
        if (x.clr) begin
            m_sc = 0; m_ac = 0; m_bc = 0;
        end else begin
            m_sc = sat(m_sc + int'(e0 || e1));
            m_ac = sat(m_ac + int'(p1.oa0) + int'(p1.oa1));
            m_bc = sat(m_bc + int'(p1.ob0) + int'(p1.ob1));
        end
        if (m_mode == 1) begin
            if (!x.us || e0 || e1) begin
                m_mode = 2;
                m_s    = c - 1;
                m_l    = int'(x.len);
                m_p    = x.us && e1;
            end
        end else if ((m_mode == 0 || (m_mode == 2 && c >= m_s + 3 + m_l)) && x.arm) begin
            m_mode = 1;
        end
    endtask

    task automatic compare_cycle();
        logic [NBITS-1:0] a0, a1, b0, b1;
        logic oa0, oa1, ob0, ob1;
        bit v, f, l, bz, dn;
        v  = (m_mode == 2) && (n >= m_s + 3) && (n <= m_s + 2 + m_l);
        f  = v && (n == m_s + 3);
        l  = v && (n == m_s + 2 + m_l);
        bz = (m_mode == 1) || (m_mode == 2 && n <= m_s + 2 + m_l);
        dn = (m_mode == 2) && (n >= m_s + 3 + m_l);
        if (v) begin
            if (!m_p) begin
                a0 = hist[n-3].da0; a1 = hist[n-3].da1;
                b0 = hist[n-3].db0; b1 = hist[n-3].db1;
                oa0 = hist[n-3].oa0; oa1 = hist[n-3].oa1;
                ob0 = hist[n-3].ob0; ob1 = hist[n-3].ob1;
            end else begin
                a0 = hist[n-3].da1; a1 = hist[n-2].da0;
                b0 = hist[n-3].db1; b1 = hist[n-2].db0;
                oa0 = hist[n-3].oa1; oa1 = hist[n-2].oa0;
                ob0 = hist[n-3].ob1; ob1 = hist[n-2].ob0;
            end
            m_dout = {b1, b0, a1, a0};
            m_ovr  = {ob1, ob0, oa1, oa0};
        end
        chk_eq("dout_valid", 64'(dout_valid), 64'(v));
        chk_eq("dout_first", 64'(dout_first), 64'(f));
        chk_eq("dout_last",  64'(dout_last),  64'(l));
        chk_eq("busy",       64'(busy),       64'(bz));
        chk_eq("done",       64'(done),       64'(dn));
        chk_eq("sync_phase", 64'(sync_phase), 64'(m_p));
        chk_eq("dout",       64'(dout),       64'(m_dout));
        chk_eq("dout_ovr",   64'(dout_ovr),   64'(m_ovr));
        chk_eq("sync_cnt",   64'(sync_cnt),   64'(m_sc));
        chk_eq("ovra_cnt",   64'(ovra_cnt),   64'(m_ac));
        chk_eq("ovrb_cnt",   64'(ovrb_cnt),   64'(m_bc));
    endtask

    task automatic drive_cycle(input stim_t st);
        stim_t rec;
        if (n >= MAXC) begin
            $display("FAIL cycle_budget: got %0d cycles, limit %0d", n, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        @(posedge clk);
        #1;
        rec = st;
        if (st.rst) begin
            rec     = '0;
            rec.rst = 1'b1;
        end
        rst = rec.rst; da_0 = rec.da0; da_1 = rec.da1; db_0 = rec.db0; db_1 = rec.db1;
        sync_0 = rec.s0; sync_1 = rec.s1;
        ovra_0 = rec.oa0; ovra_1 = rec.oa1; ovrb_0 = rec.ob0; ovrb_1 = rec.ob1;
        arm = rec.arm; use_sync = rec.us; cap_len = rec.len; ovr_clr = rec.clr;
        hist[n] = rec;
        model_step(n - 1);
        @(negedge clk);
        if (m_ready) compare_cycle();
        n++;
    endtask

    function automatic stim_t quiet_stim(input bit us, input int len);
        stim_t s;
        s     = '0;
        s.da0 = NBITS'($urandom); s.da1 = NBITS'($urandom);
        s.db0 = NBITS'($urandom); s.db1 = NBITS'($urandom);
        s.us  = us;
        s.len = LEN_W'(len);
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s     = quiet_stim(1'($urandom), int'($urandom_range(0, 6)));
        s.s0  = ($urandom_range(0, 5) == 0);
        s.s1  = ($urandom_range(0, 5) == 0);
        s.oa0 = ($urandom_range(0, 7) == 0);
        s.oa1 = ($urandom_range(0, 7) == 0);
        s.ob0 = ($urandom_range(0, 7) == 0);
        s.ob1 = ($urandom_range(0, 7) == 0);
        s.arm = ($urandom_range(0, 3) == 0);
        s.clr = ($urandom_range(0, 63) == 0);
        s.rst = ($urandom_range(0, 399) == 0);
        return s;
    endfunction

    initial begin
        stim_t st;
        for (int i = 0; i < 4; i++) begin
            hist[i]     = '0;
            hist[i].rst = 1'b1;
        end
        n = 4; n_cmp = 0; n_err = 0; m_ready = 1'b0;
        m_mode = 0; m_s = 0; m_l = 0; m_p = 1'b0; m_dout = '0; m_ovr = '0;
        m_sc = 0; m_ac = 0; m_bc = 0;
        rst = 1'b1; da_0 = '0; da_1 = '0; db_0 = '0; db_1 = '0;
        sync_0 = 1'b0; sync_1 = 1'b0; ovra_0 = 1'b0; ovra_1 = 1'b0;
        ovrb_0 = 1'b0; ovrb_1 = 1'b0; arm = 1'b0; use_sync = 1'b0;
        cap_len = '0; ovr_clr = 1'b0;

        st = '0; st.rst = 1'b1;
        repeat (3) drive_cycle(st);

        // Sync start on lane 0, four words.
        st = quiet_stim(1'b1, 4); st.arm = 1'b1; drive_cycle(st);
        repeat (2) drive_cycle(quiet_stim(1'b1, 4));
        st = quiet_stim(1'b1, 4); st.s0 = 1'b1; drive_cycle(st);
        repeat (10) drive_cycle(quiet_stim(1'b1, 4));

        // Sync start on lane 1, re-armed from done.
        st = quiet_stim(1'b1, 4); st.arm = 1'b1; drive_cycle(st);
        repeat (2) drive_cycle(quiet_stim(1'b1, 4));
        st = quiet_stim(1'b1, 4); st.s1 = 1'b1; drive_cycle(st);
        repeat (10) drive_cycle(quiet_stim(1'b1, 4));

        // Immediate start, one word then zero words.
        st = quiet_stim(1'b0, 1); st.arm = 1'b1; drive_cycle(st);
        repeat (6) drive_cycle(quiet_stim(1'b0, 1));
        st = quiet_stim(1'b0, 0); st.arm = 1'b1; drive_cycle(st);
        repeat (6) drive_cycle(quiet_stim(1'b0, 0));

        repeat (3000) drive_cycle(rand_stim());

        // Counter saturation, then clear colliding with an increment.
        st = '0; st.rst = 1'b1; drive_cycle(st);
        repeat (40000) begin
            st = quiet_stim(1'b0, 0); st.oa0 = 1'b1; st.oa1 = 1'b1; drive_cycle(st);
        end
        st = quiet_stim(1'b0, 0); st.oa0 = 1'b1; st.oa1 = 1'b1; st.clr = 1'b1; drive_cycle(st);
        repeat (3) drive_cycle(quiet_stim(1'b0, 0));

        // Reset in the middle of a long capture, arm held high throughout.
        repeat (52) begin
            st = quiet_stim(1'b0, 100); st.arm = 1'b1; drive_cycle(st);
        end
        st = '0; st.rst = 1'b1; drive_cycle(st);
        repeat (12) drive_cycle(quiet_stim(1'b0, 100));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
